mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one slow off-chip memory port between the instruction cache and the data cache.
//  Each cache keeps its native miss interface: read/write strobe, 28-bit block address, 128-bit block.
//  One transaction is in flight at a time. Grant is round-robin, or fixed data-first.
//  Sits in CHIP between I_cache/D_cache and the single slow_mem model.
// PARAMETERS
//  ADDR_W  28   block address width (byte address bits [31:4])
//  DATA_W  128  block width in bits
//  ARB_RR  1    1: round-robin on contention; 0: fixed priority, D wins
// PORTS
//  clk           in   1       clock; everything is sampled on the rising edge
//  rst           in   1       synchronous, active-high reset
//  i_mem_read    in   1       I-cache block read request
//  i_mem_write   in   1       I-cache block write request
//  i_mem_addr    in   ADDR_W  I-cache block address
//  i_mem_wdata   in   DATA_W  I-cache write block
//  i_mem_rdata   out  DATA_W  read block returned to I-cache
//  i_mem_ready   out  1       I-cache transaction done (1-cycle pulse)
//  d_mem_*       (same six signals, same directions and widths, for the D-cache)
//  mem_read      out  1       slow-memory read strobe
//  mem_write     out  1       slow-memory write strobe
//  mem_addr      out  ADDR_W  slow-memory block address
//  mem_wdata     out  DATA_W  slow-memory write block
//  mem_rdata     in   DATA_W  slow-memory read block
//  mem_ready     in   1       slow-memory transaction done
//  grant_d       out  1       1 while the D-cache owns the port (debug/bench)
// BEHAVIOUR
//  Reset (synchronous, active-high):
//   - FSM to IDLE; mem_read, mem_write, grant_d = 0; mem_addr, mem_wdata = 0.
//   - RR pointer favours D; both *_mem_ready = 0.
//  FSM states: IDLE, SERVE_I, SERVE_D.
//  Request definitions: req_i = i_mem_read | i_mem_write; req_d likewise.
//  IDLE:
//   - Outputs low. If any request is present, pick the winner.
//   - Winner rule: ARB_RR=1 -> the cache not granted last; ARB_RR=0 -> D.
//   - Next edge: go to SERVE_x; register the winner's addr, wdata and strobes onto mem_*.
//   - Latency: request at cycle t -> mem_* valid from t+1.
//  SERVE_x:
//   - mem_* are held constant from the registered copy. Requester changes are ignored,
//     except withdrawal (below).
//   - x_mem_ready = mem_ready & (state==SERVE_x), combinational.
//   - x_mem_rdata = mem_rdata, combinational pass-through to the granted cache only.
//   - Non-granted cache sees ready=0 and rdata=0.
//   - When mem_ready=1: next edge -> IDLE; strobes drop; RR pointer updates to x.
//  Turnaround: at least one IDLE cycle, with strobes low, between back-to-back memory transactions.
//  Read and write both high from one cache: write wins; the read is not forwarded.
//  Withdrawal: granted request drops before mem_ready.
//   - Next edge -> IDLE; strobes drop; no ready pulse.
//   - Pointer is not updated.
//  Ready outside SERVE, or while strobes are low: ignored.
//  Reset mid-transaction: strobes low at the next edge; the in-flight access is abandoned; no ready pulse.
//  No starvation with ARB_RR=1: each requester waits at most one foreign transaction.
// STRUCTURE
//  Shared package (mem_arb_pkg):
//   - state encoding constants ST_IDLE=2'd0, ST_SERVE_I=2'd1, ST_SERVE_D=2'd2;
//   - ADDR_W / DATA_W defaults.
//  Single module, no submodules. Registered command path, combinational return path.
// TESTING
//  1. Reset held 3 cycles while both caches request
//     -> all mem_* = 0, grant_d = 0; first grant after release goes to D.
//  2. I-read only, addr 28'h0000010, memory ready after 5 cycles with rdata 128'hA5..A5
//     -> mem_read=1 from t+1; i_mem_ready pulses once; i_mem_rdata = A5..A5;
//        d_mem_ready stays 0.
//  3. Both caches request continuously, ARB_RR=1
//     -> grant order D,I,D,I; one IDLE cycle between transactions.
//  4. Both request continuously, ARB_RR=0 -> D served every time; I waits.
//  5. D raises read and write together, addr 28'h0001234, wdata 128'h1
//     -> mem_write=1, mem_read=0, mem_wdata=1.
//  6. Granted I drops its request at cycle 2 of service
//     -> IDLE next edge; no i_mem_ready; a pending D request is granted next.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, default widths and strobe decode for mem_arbiter
package mem_arb_pkg;

    localparam int MEM_ADDR_W = 28;
    localparam int MEM_DATA_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_I = 2'd1,
        ST_SERVE_D = 2'd2
    } arb_state_t;

    // Returns {write, read}; a write suppresses a simultaneous read from the same cache
    function automatic logic [1:0] strobes(input logic rd, input logic wr);
        return {wr, rd & ~wr};
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one slow memory port between the I-cache and D-cache,
// one transaction at a time, round-robin or fixed D-first arbitration.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter int ARB_RR = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              grant_d
);

    arb_state_t state, state_nx;
    logic req_i, req_d, win_d, serve_i, serve_d, load, done;
    logic last_d;

    always_comb begin
        req_i    = i_mem_read | i_mem_write;
        req_d    = d_mem_read | d_mem_write;
        serve_i  = state == ST_SERVE_I;
        serve_d  = state == ST_SERVE_D;
        // last_d=0 after reset so D wins the first contention
        win_d    = req_d & (~req_i | (ARB_RR == 0) | ~last_d);
        state_nx = state;
        load     = 1'b0;
        done     = 1'b0;
        if (state == ST_IDLE) begin
            if (req_i | req_d) begin
                state_nx = win_d ? ST_SERVE_D : ST_SERVE_I;
                load     = 1'b1;
            end
        end else if (!(serve_i | serve_d)) begin
            state_nx = ST_IDLE;
        end else if (mem_ready) begin
            state_nx = ST_IDLE;
            done     = 1'b1;
        end else if (!(serve_d ? req_d : req_i)) begin
            state_nx = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            last_d    <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state <= state_nx;
            if (done)
                last_d <= serve_d;
            if (load) begin
                {mem_write, mem_read} <= win_d ? strobes(d_mem_read, d_mem_write)
                                               : strobes(i_mem_read, i_mem_write);
                mem_addr  <= win_d ? d_mem_addr : i_mem_addr;
                mem_wdata <= win_d ? d_mem_wdata : i_mem_wdata;
            end else if (state_nx == ST_IDLE) begin
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
                mem_addr  <= '0;
                mem_wdata <= '0;
            end
        end
    end

    // Return path is combinational; reset masks a ready arriving in the reset cycle
    assign grant_d     = serve_d;
    assign i_mem_ready = mem_ready & serve_i & ~rst;
    assign d_mem_ready = mem_ready & serve_d & ~rst;
    assign i_mem_rdata = serve_i ? mem_rdata : '0;
    assign d_mem_rdata = serve_d ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter (round-robin and fixed-priority instances)
module tb_mem_arbiter;

    localparam int LAT = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_mem_read, i_mem_write, d_mem_read, d_mem_write;
    logic [27:0]  i_mem_addr, d_mem_addr;
    logic [127:0] i_mem_wdata, d_mem_wdata;
    logic [127:0] i_mem_rdata, d_mem_rdata, fp_i_mem_rdata, fp_d_mem_rdata;
    logic         i_mem_ready, d_mem_ready, fp_i_mem_ready, fp_d_mem_ready;
    logic         mem_read, mem_write, fp_mem_read, fp_mem_write;
    logic [27:0]  mem_addr, fp_mem_addr;
    logic [127:0] mem_wdata, fp_mem_wdata, mem_rdata, fp_mem_rdata;
    logic         mem_ready, fp_mem_ready, grant_d, fp_grant_d;
    logic         model_rdy, fp_rdy, extra_rdy;
    logic [2:0]   cnt, fp_cnt;
    logic [127:0] model_data;
    logic [158:0] exp_q[$];
    logic [158:0] e;
    logic         prev_s;
    int checks = 0, failures = 0;
    int i_pulses = 0, d_pulses = 0, fp_i_pulses = 0, fp_d_pulses = 0;
    int ib, db;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(28), .DATA_W(128), .ARB_RR(1)) dut (
        .clk(clk), .rst(rst),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_addr(i_mem_addr),
        .i_mem_wdata(i_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_addr(d_mem_addr),
        .d_mem_wdata(d_mem_wdata), .d_mem_rdata(d_mem_rdata), .d_mem_ready(d_mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant_d(grant_d)
    );

    mem_arbiter #(.ADDR_W(28), .DATA_W(128), .ARB_RR(0)) dut_fp (
        .clk(clk), .rst(rst),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_addr(i_mem_addr),
        .i_mem_wdata(i_mem_wdata), .i_mem_rdata(fp_i_mem_rdata), .i_mem_ready(fp_i_mem_ready),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_addr(d_mem_addr),
        .d_mem_wdata(d_mem_wdata), .d_mem_rdata(fp_d_mem_rdata), .d_mem_ready(fp_d_mem_ready),
        .mem_read(fp_mem_read), .mem_write(fp_mem_write), .mem_addr(fp_mem_addr),
        .mem_wdata(fp_mem_wdata), .mem_rdata(fp_mem_rdata), .mem_ready(fp_mem_ready),
        .grant_d(fp_grant_d)
    );

    // Slow memory models: ready one cycle, LAT cycles after strobes rise
    always @(posedge clk) begin
        if (rst || !(mem_read || mem_write) || model_rdy) begin
            cnt <= 3'd0;
            model_rdy <= 1'b0;
        end else begin
            cnt <= cnt + 3'd1;
            model_rdy <= (cnt == 3'(LAT - 1));
        end
    end

    always @(posedge clk) begin
        if (rst || !(fp_mem_read || fp_mem_write) || fp_rdy) begin
            fp_cnt <= 3'd0;
            fp_rdy <= 1'b0;
        end else begin
            fp_cnt <= fp_cnt + 3'd1;
            fp_rdy <= (fp_cnt == 3'(LAT - 1));
        end
    end

    assign mem_ready    = model_rdy | extra_rdy;
    assign mem_rdata    = mem_ready ? model_data : '0;
    assign fp_mem_ready = fp_rdy;
    assign fp_mem_rdata = fp_rdy ? model_data : '0;

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: each new transaction start pops one expected command
    initial prev_s = 1'b0;
    always @(negedge clk) begin
        if ((mem_read || mem_write) && !prev_s) begin
            if (exp_q.size() == 0)
                check("unexpected_txn", 1, 0);
            else
                check("txn_cmd", {1'b0, grant_d, mem_read, mem_write, mem_addr, mem_wdata},
                      {1'b0, exp_q.pop_front()});
        end
        prev_s = mem_read | mem_write;
        if (i_mem_ready) begin
            i_pulses++;
            check("i_rdata", i_mem_rdata, model_data);
            check("d_rdata_other", d_mem_rdata, 0);
        end
        if (d_mem_ready) begin
            d_pulses++;
            check("d_rdata", d_mem_rdata, model_data);
            check("i_rdata_other", i_mem_rdata, 0);
        end
        if (fp_i_mem_ready) fp_i_pulses++;
        if (fp_d_mem_ready) fp_d_pulses++;
    end

    task automatic wait_done(input int n);
        int seen = 0;
        int k = 0;
        while (seen < n && k < 300) begin
            @(negedge clk);
            k++;
            if (i_mem_ready || d_mem_ready) seen++;
        end
        check("ready_count_or_timeout", seen, n);
    endtask

    task automatic idle_all();
        i_mem_read = 0; i_mem_write = 0; d_mem_read = 0; d_mem_write = 0;
    endtask

    initial begin
        rst = 1; extra_rdy = 0; model_data = {16{8'hA5}};
        i_mem_read = 1; i_mem_write = 0; i_mem_addr = 28'h0000100; i_mem_wdata = 128'h11;
        d_mem_read = 1; d_mem_write = 0; d_mem_addr = 28'h0000200; d_mem_wdata = 128'h22;
        // Reset held 3 cycles while both request
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", {mem_read, mem_write, grant_d, i_mem_ready, d_mem_ready, mem_addr, mem_wdata}, 0);
        end
        // Round-robin contention: D,I,D,I
        for (int n = 0; n < 2; n++) begin
            exp_q.push_back({1'b1, 1'b1, 1'b0, 28'h0000200, 128'h22});
            exp_q.push_back({1'b0, 1'b1, 1'b0, 28'h0000100, 128'h11});
        end
        rst = 0;
        wait_done(4);
        idle_all();
        repeat (3) @(negedge clk);
        check("rr_queue_drained", exp_q.size(), 0);
        check("fp_i_never_served", fp_i_pulses, 0);
        check("fp_d_served_repeatedly", fp_d_pulses >= 3, 1);
        // Single I read, latency and ready pulse
        ib = i_pulses; db = d_pulses;
        i_mem_addr = 28'h0000010; i_mem_wdata = '0;
        exp_q.push_back({1'b0, 1'b1, 1'b0, 28'h0000010, 128'h0});
        check("strobe_low_at_t", mem_read, 0);
        i_mem_read = 1;
        @(negedge clk);
        check("mem_read_at_t1", mem_read, 1);
        wait_done(1);
        idle_all();
        repeat (2) @(negedge clk);
        check("i_one_pulse", i_pulses, ib + 1);
        check("d_no_pulse", d_pulses, db);
        // Ready while idle is ignored
        extra_rdy = 1;
        #1;
        check("idle_ready_ignored", {i_mem_ready, d_mem_ready, i_mem_rdata, d_mem_rdata}, 0);
        @(negedge clk);
        check("idle_stays_idle", {mem_read, mem_write, grant_d}, 0);
        extra_rdy = 0;
        @(negedge clk);
        // D read+write together: write wins; later requester changes ignored
        db = d_pulses;
        d_mem_addr = 28'h0001234; d_mem_wdata = 128'h1;
        exp_q.push_back({1'b1, 1'b0, 1'b1, 28'h0001234, 128'h1});
        d_mem_read = 1; d_mem_write = 1;
        @(negedge clk);
        d_mem_addr = 28'hFFFFFFF; d_mem_wdata = 128'hDEAD;
        @(negedge clk);
        check("held_cmd", {mem_read, mem_write, mem_addr, mem_wdata}, {1'b0, 1'b1, 28'h0001234, 128'h1});
        wait_done(1);
        idle_all();
        repeat (2) @(negedge clk);
        check("d_write_pulse", d_pulses, db + 1);
        // Withdrawal of granted I at service cycle 2; pending D then granted
        ib = i_pulses; db = d_pulses;
        i_mem_addr = 28'h0000020; i_mem_wdata = '0;
        exp_q.push_back({1'b0, 1'b1, 1'b0, 28'h0000020, 128'h0});
        i_mem_read = 1;
        @(negedge clk);
        d_mem_addr = 28'h0000055; d_mem_wdata = '0; d_mem_read = 1;
        @(negedge clk);
        exp_q.push_back({1'b1, 1'b1, 1'b0, 28'h0000055, 128'h0});
        i_mem_read = 0;
        @(negedge clk);
        check("withdraw_idle", {mem_read, mem_write, grant_d}, 0);
        wait_done(1);
        idle_all();
        repeat (2) @(negedge clk);
        check("withdraw_no_i_ready", i_pulses, ib);
        check("pending_d_served", d_pulses, db + 1);
        // Reset mid-transaction: abandoned, no ready, pointer back to D
        ib = i_pulses;
        i_mem_addr = 28'h0000077;
        exp_q.push_back({1'b0, 1'b1, 1'b0, 28'h0000077, 128'h0});
        i_mem_read = 1;
        repeat (2) @(negedge clk);
        rst = 1; extra_rdy = 1;
        #1;
        check("reset_masks_ready", i_mem_ready, 0);
        @(negedge clk);
        check("reset_drops_strobes", {mem_read, mem_write, grant_d}, 0);
        rst = 0; extra_rdy = 0; idle_all();
        repeat (2) @(negedge clk);
        check("reset_no_i_ready", i_pulses, ib);
        db = d_pulses;
        i_mem_addr = 28'h0000101; d_mem_addr = 28'h0000202; d_mem_wdata = 128'h3;
        exp_q.push_back({1'b1, 1'b1, 1'b0, 28'h0000202, 128'h3});
        i_mem_read = 1; d_mem_read = 1;
        wait_done(1);
        idle_all();
        repeat (3) @(negedge clk);
        check("d_first_after_reset", d_pulses, db + 1);
        check("final_queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
